vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates raster timing for the 640x480 display path on vga_clk: DrawX/DrawY pixel coordinates, active-video flag blank, and active-low hs/vs syncs.
- Feeds the per-pixel renderers (ROM/palette background, sprites), which consume DrawX/DrawY/blank and register RGB a fixed number of cycles later.
- Also provides delayed copies of blank/hs/vs so the syncs at the pins line up with that renderer latency.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- PIPE_DELAY, 2, renderer latency in clocks for the *_d outputs; legal range 0..7

Ports:
- vga_clk  in  1  pixel clock (25 MHz nominal)
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
- hs  out  1  active-low hsync, aligned with DrawX
- vs  out  1  active-low vsync, aligned with DrawY
- line_start  out  1  one-clock pulse when DrawX==0
- frame_start  out  1  one-clock pulse when DrawX==0 and DrawY==0
- blank_d, hs_d, vs_d  out  1 each  blank/hs/vs delayed PIPE_DELAY clocks

Behaviour:
- One clock (vga_clk). Reset is asynchronous and active-low (reset_n); it is fixed that way.
- H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525. Frame = 420000 clocks.
- While reset_n=0, every output is held at its reset value:
  - DrawX=0, DrawY=0, blank=0
  - hs=1, vs=1
  - line_start=0, frame_start=0
  - blank_d=0, hs_d=1, vs_d=1; all delay stages hold the same reset values.
- Two-state FSM: ARM and RUN. Reset enters ARM.
  - ARM, first rising edge after release: counters stay (0,0); blank=1, line_start=1, frame_start=1; go to RUN. Pixel (0,0) is therefore never skipped.
  - RUN, each edge: DrawX increments.
  - When DrawX==H_TOTAL-1: DrawX wraps to 0 and DrawY increments; DrawY wraps to 0 after V_TOTAL-1.
- All outputs are registers. blank, hs, vs, line_start and frame_start are decoded from the next counter values, so they change on the same edge as DrawX/DrawY (zero relative skew).
- Decode windows:
  - hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole line.
- Delayed outputs:
  - blank_d/hs_d/vs_d come from a PIPE_DELAY-deep shift register.
  - PIPE_DELAY=0 makes them combinational copies of blank/hs/vs.
  - During the first PIPE_DELAY clocks after release they still present reset values.
- Widths: counters are 10 bits; compare in unsigned 10-bit. Parameter sums must be less than 1024; check this with an elaboration-time assertion.
- Reset asserted mid-frame: outputs go to reset values immediately, with no clock needed. After release the FSM re-enters ARM and restarts at (0,0) with frame_start.
- No enable or stall input. Timing is free-running once in RUN.

Decomposition:
- Package vga_timing_pkg:
  - localparams H_VISIBLE..V_BACK, H_TOTAL, V_TOTAL
  - HS_START/HS_END, VS_START/VS_END
  - typedef coord_t = logic [9:0]
  - enum tg_state_t {ARM, RUN}
- Sub-module vga_pipe_delay:
  - Parameters WIDTH and DEPTH; async active-low reset; parameterised reset value.
  - Instantiated once, 3 bits wide, for {blank, hs, vs}.

Test Plan:
- Reset release: hold reset_n=0 for 5 clocks, then release. Check outputs all at reset values while held. On the first edge: DrawX=0, DrawY=0, blank=1, frame_start=1. Next edge: DrawX=1, frame_start=0.
- Line timing: count clocks from line_start to line_start = 800. In each line, blank=1 for exactly 640 clocks, and hs=0 exactly for DrawX 656..751 (96 clocks).
- Frame timing: clocks between frame_start pulses = 420000. vs=0 only for DrawY 490..491 (1600 clocks). blank=0 for all DrawY >= 480.
- Wrap: at DrawX=799, DrawY=524 the next edge gives DrawX=0, DrawY=0, frame_start=1, blank=1.
- Mid-frame reset: assert reset_n=0 asynchronously at DrawX=300, DrawY=200. Outputs drop to reset values before the next edge. After release, the first edge gives (0,0) with frame_start=1.
- PIPE_DELAY=2 (and 0): at every clock, hs_d/vs_d/blank_d equal hs/vs/blank from 2 (or 0) clocks earlier, compared against the bench's own model.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate type and generator FSM states.
// Constants only: no logic, no latency, no backpressure.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [9:0] coord_t;

  typedef enum logic {ARM, RUN} tg_state_t;

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with async active-low reset to a programmable value.
// Latency DEPTH clocks (DEPTH=0 is a wire); no backpressure, shifts every clock.
module vga_pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing: DrawX/DrawY, blank, hs/vs, line/frame pulses, plus delayed syncs.
// Outputs registered, zero skew to counters; *_d lag PIPE_DELAY clocks; no stall input.
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic       blank_d,
  output logic       hs_d,
  output logic       vs_d
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOT >= 1024 || V_TOT >= 1024) begin : g_bad_totals
      $error("vga_timing_gen: line/frame totals must fit in 10-bit counters");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end
  endgenerate

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  tg_state_t state;
  coord_t    nx, ny;

  // In ARM the counters hold at (0,0) so the first edge after reset presents pixel (0,0).
  always_comb begin
    nx = DrawX;
    ny = DrawY;
    if (state == RUN) begin
      if (DrawX == H_LAST) begin
        nx = '0;
        ny = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
      end else begin
        nx = DrawX + coord_t'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARM;
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        ARM:     state <= RUN;
        default: state <= RUN;
      endcase
      DrawX       <= nx;
      DrawY       <= ny;
      blank       <= (nx < H_VIS) && (ny < V_VIS);
      hs          <= !((nx >= HS_LO) && (nx < HS_HI));
      vs          <= !((ny >= VS_LO) && (ny < VS_HI));
      line_start  <= (nx == '0);
      frame_start <= (nx == '0) && (ny == '0);
    end
  end

  vga_pipe_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (3'b011)
  ) u_pipe (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     ({blank, hs, vs}),
    .q     ({blank_d, hs_d, vs_d})
  );

endmodule
